// File: rtl/logic_seq_pkg.sv
// Shared encodings for the logic set sequencer: operation codes and FSM states.
package logic_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOT     = 3'd0,
        OP_AND     = 3'd1,
        OP_OR      = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XOR     = 3'd5,
        OP_XNOR    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_nbit_unit.sv
// Combinational WIDTH-bit logic unit; b is don't-care for NOT, illegal op yields 0.
module logic_nbit_unit
    import logic_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_set_sequencer.sv
// Applies one logic op to SETS packed operand sets, one set per cycle through a single shared unit.
module logic_set_sequencer
    import logic_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SETS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [SETS*WIDTH-1:0] in1_packed,
    input  logic [SETS*WIDTH-1:0] in2_packed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SETS*WIDTH-1:0] out_packed,
    output logic                  err,
    output logic                  busy,
    output state_e                state_dbg
);

    localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here are decoded from state only.
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    op_e                   op_q, op_d;
    logic [SETS*WIDTH-1:0] a_q, a_d;
    logic [SETS*WIDTH-1:0] b_q, b_d;
    logic [SETS*WIDTH-1:0] out_q, out_d;
    logic                  err_q, err_d;

    logic [WIDTH-1:0]      unit_a, unit_b, unit_y;

    assign unit_a = a_q[idx_q*WIDTH +: WIDTH];
    assign unit_b = b_q[idx_q*WIDTH +: WIDTH];

    logic_nbit_unit #(.WIDTH(WIDTH)) u_unit (
        .op (op_q),
        .a  (unit_a),
        .b  (unit_b),
        .y  (unit_y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = op_e'(op);
                    a_d   = in1_packed;
                    b_d   = in2_packed;
                    out_d = '0;
                    idx_d = '0;
                    if (op_e'(op) == OP_ILLEGAL) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                out_d[idx_q*WIDTH +: WIDTH] = unit_y;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_NOT;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_packed = out_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_logic_set_sequencer.sv
// Directed bench for logic_set_sequencer at WIDTH=4, SETS=2.
module tb_logic_set_sequencer;
    import logic_seq_pkg::*;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int PW = W * S;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [PW-1:0] in1;
    logic [PW-1:0] in2;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_packed;
    logic          err;
    logic          busy;
    state_e        state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_a, acc_b, n;

    logic_set_sequencer #(.WIDTH(W), .SETS(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .in1_packed (in1),
        .in2_packed (in2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packed (out_packed),
        .err        (err),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready high; returns the cycle of the accepting edge.
    task automatic do_txn(input string tag, input logic [2:0] o, input logic [PW-1:0] a,
                          input logic [PW-1:0] b, input logic [PW-1:0] exp_out,
                          input logic exp_err, input bit scramble, output int acc_cyc);
        int k;
        op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            if (scramble) begin
                op       = 3'($urandom_range(0, 7));
                in1      = PW'($urandom_range(0, 255));
                in2      = PW'($urandom_range(0, 255));
                in_valid = 1'($urandom_range(0, 1));
            end
            tick;
            k++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, k, exp_err ? 0 : S);
        check({tag, "_out"}, out_packed, exp_out);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_done"}, in_ready, 0);
        tick;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_err_clear"}, err, 0);
        check({tag, "_idle"}, in_ready, 1);
        check({tag, "_out_kept"}, out_packed, exp_out);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", out_packed, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        do_txn("and", 3'd1, 8'hC5, 8'h3F, 8'h05, 1'b0, 1'b0, acc_a);
        do_txn("not", 3'd0, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0, acc_b);
        check("throughput", acc_b - acc_a, S + 2);
        do_txn("xor", 3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, acc_a);
        do_txn("ill", 3'd7, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, acc_a);
        do_txn("nand", 3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, acc_a);

        // Consumer stalls for 3 cycles while a new request is offered.
        op = 3'd6; in1 = 8'h3C; in2 = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
        check("stall_latency", n, S);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 3'd1; in1 = 8'h00; in2 = 8'h00;
            tick;
            check("stall_valid", out_valid, 1);
            check("stall_out", out_packed, 8'hFF);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        check("stall_release", out_valid, 0);
        check("stall_out_kept", out_packed, 8'hFF);

        // Reset during the first RUN cycle of an OR.
        op = 3'd2; in1 = 8'h12; in2 = 8'h34; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("run_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rrun_out_valid", out_valid, 0);
        check("rrun_busy", busy, 0);
        check("rrun_in_ready", in_ready, 1);
        check("rrun_out", out_packed, 0);
        check("rrun_err", err, 0);
        check("rrun_state", state_dbg, ST_IDLE);
        #2;
        rst = 1'b0;
        tick;
        do_txn("nor", 3'd4, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, acc_a);

        // Reset while holding a finished result.
        op = 3'd2; in1 = 8'h12; in2 = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("or_valid", out_valid, 1);
        check("or_out", out_packed, 8'h36);
        rst = 1'b1;
        #1;
        check("rdone_out", out_packed, 0);
        check("rdone_valid", out_valid, 0);
        check("rdone_in_ready", in_ready, 1);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        tick;

        do_txn("scramble", 3'd1, 8'h96, 8'h5A, 8'h12, 1'b0, 1'b1, acc_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
